// File: rtl/serial_seq_tx.sv
// Serial sequence transmitter: parallel words in over valid/ready,
// shifted out LSB-first on d_out with an optional idle gap per word.
module serial_seq_tx #(
    parameter int   WIDTH    = 16,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             d_out,
    output logic             busy,
    output logic             word_done,
    output logic [7:0]       word_cnt
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    localparam logic [3:0] GLAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [IW-1:0]    idx;
    logic [3:0]       gcnt;
    logic             last;

    assign last      = (state == S_SHIFT) && (idx == LAST);
    assign din_ready = (state == S_IDLE) || (last && (GAP == 0));
    assign busy      = (state != S_IDLE);
    assign word_done = last;

    // sreg holds the bits not yet on d_out; bit 0 goes out at load time
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            d_out    <= IDLE_LVL;
            word_cnt <= 8'd0;
            idx      <= '0;
            gcnt     <= 4'd0;
            sreg     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (din_valid) begin
                        state <= S_SHIFT;
                        sreg  <= din >> 1;
                        d_out <= din[0];
                        idx   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!last) begin
                        d_out <= sreg[0];
                        sreg  <= sreg >> 1;
                        idx   <= idx + 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 8'd1;
                        if (GAP > 0) begin
                            state <= S_GAP;
                            gcnt  <= 4'd0;
                            d_out <= IDLE_LVL;
                        end else if (din_valid) begin
                            sreg  <= din >> 1;
                            d_out <= din[0];
                            idx   <= '0;
                        end else begin
                            state <= S_IDLE;
                            d_out <= IDLE_LVL;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt == GLAST) state <= S_IDLE;
                    else gcnt <= gcnt + 4'd1;
                end
                default: begin
                    state <= S_IDLE;
                    d_out <= IDLE_LVL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_seq_tx.sv
// Directed bench for serial_seq_tx: u_g1 uses GAP=1, u_g0 uses GAP=0.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_serial_seq_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] din;
    logic        din_valid;

    logic        rdy1, dout1, busy1, done1;
    logic [7:0]  cnt1;
    logic        rdy0, dout0, busy0, done0;
    logic [7:0]  cnt0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_seq_tx #(.WIDTH(16), .GAP(1), .IDLE_LVL(1'b0)) u_g1 (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .d_out(dout1), .busy(busy1),
        .word_done(done1), .word_cnt(cnt1)
    );

    serial_seq_tx #(.WIDTH(16), .GAP(0), .IDLE_LVL(1'b0)) u_g0 (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .d_out(dout0), .busy(busy0),
        .word_done(done0), .word_cnt(cnt0)
    );

    // seq: bits in time order, first bit sent in the MSB
    typedef struct {
        logic [15:0] word;
        logic [15:0] seq;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // send one word on the GAP=1 instance and check the full frame
    task automatic send_g1(input logic [15:0] w, input logic [15:0] seq,
                           input logic [7:0] cnt_after);
        din       = w;
        din_valid = 1'b1;
        chk("ready_before", 32'(rdy1), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            din       = 16'h5A5A;
            chk($sformatf("bit%0d", i), 32'(dout1), 32'(seq[15-i]));
            chk($sformatf("done%0d", i), 32'(done1), 32'(i == 15));
        end
        @(negedge clk);
        chk("gap_dout", 32'(dout1), 32'd0);
        chk("gap_busy", 32'(busy1), 32'd1);
        chk("gap_ready", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("end_busy", 32'(busy1), 32'd0);
        chk("end_cnt", 32'(cnt1), 32'(cnt_after));
    endtask

    initial begin
        int seen;
        int cyc;

        vecs[0] = '{16'b0010_0101_0110_1010, 16'b0101_0110_1010_0100};
        vecs[1] = '{16'h0001, 16'h8000};
        vecs[2] = '{16'h8000, 16'h0001};
        vecs[3] = '{16'hAAAA, 16'h5555};
        vecs[4] = '{16'h00F0, 16'h0F00};
        vecs[5] = '{16'h1234, 16'h2C48};

        reset_n   = 1'b0;
        din_valid = 1'b1;
        din       = 16'hFFFF;

        // reset held 3 cycles with valid high
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_dout", 32'(dout1), 32'd0);
            chk("rst_busy", 32'(busy1), 32'd0);
            chk("rst_cnt", 32'(cnt1), 32'd0);
            chk("rst_done", 32'(done1), 32'd0);
        end
        din_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(rdy1), 32'd1);

        // stall: no valid for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_dout", 32'(dout1), 32'd0);
            chk("stall_busy", 32'(busy1), 32'd0);
            chk("stall_cnt", 32'(cnt1), 32'd0);
        end

        // table of single words, back to back through the GAP=1 path
        for (int v = 0; v < 6; v++)
            send_g1(vecs[v].word, vecs[v].seq, 8'(v + 1));

        // mid-word reset at bit 7
        do_reset();
        din       = 16'hFFFF;
        din_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            chk("mw_bit", 32'(dout1), 32'd1);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("mw_dout", 32'(dout1), 32'd0);
        chk("mw_cnt", 32'(cnt1), 32'd0);
        chk("mw_busy", 32'(busy1), 32'd0);
        send_g1(vecs[0].word, vecs[0].seq, 8'd1);

        // back-to-back on GAP=0
        do_reset();
        din       = 16'h0001;
        din_valid = 1'b1;
        chk("b2b_ready0", 32'(rdy0), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 0) din = 16'h8000;
            if (i == 16) din_valid = 1'b0;
            chk($sformatf("b2b_bit%0d", i), 32'(dout0),
                32'(i == 0 || i == 31));
            chk($sformatf("b2b_rdy%0d", i), 32'(rdy0),
                32'(i == 15 || i == 31));
        end
        @(negedge clk);
        chk("b2b_cnt", 32'(cnt0), 32'd2);
        chk("b2b_busy", 32'(busy0), 32'd0);
        chk("b2b_idle", 32'(dout0), 32'd0);

        // wrap: 256 words on GAP=0
        do_reset();
        din       = 16'h00FF;
        din_valid = 1'b1;
        seen      = 0;
        cyc       = 0;
        while (seen < 256 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (done0 === 1'b1) seen++;
        end
        chk("wrap_seen", 32'(seen), 32'd256);
        din_valid = 1'b0;
        chk("wrap_255", 32'(cnt0), 32'd255);
        @(negedge clk);
        chk("wrap_0", 32'(cnt0), 32'd0);
        chk("wrap_busy", 32'(busy0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
